// File: rtl/fifo_ctrl_4x8.sv
// FIFO pointer/flow controller for the 16x8 memory_4x8: accepts push/pop,
// drives memory strobes and addresses, and reports occupancy and error flags.
module fifo_ctrl_4x8 #(
  parameter int MAIN_SIZE  = 4,
  parameter int DEPTH      = 16,
  parameter int AF_DEFAULT = 12,
  parameter int AE_DEFAULT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [MAIN_SIZE:0]   afull_thr,
  input  logic [MAIN_SIZE:0]   aempty_thr,
  input  logic                 push,
  input  logic                 pop,
  output logic                 write,
  output logic                 read,
  output logic [MAIN_SIZE-1:0] wr_ptr,
  output logic [MAIN_SIZE-1:0] rd_ptr,
  output logic                 valid_out,
  output logic [MAIN_SIZE:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow_err,
  output logic                 underflow_err
);

  localparam logic [0:0] ST_INIT   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam logic [MAIN_SIZE:0] DEPTH_C = (MAIN_SIZE+1)'(DEPTH);
  localparam logic [MAIN_SIZE:0] AF_C    = (MAIN_SIZE+1)'(AF_DEFAULT);
  localparam logic [MAIN_SIZE:0] AE_C    = (MAIN_SIZE+1)'(AE_DEFAULT);

  logic [0:0]         state;
  logic [MAIN_SIZE:0] af_thr;
  logic [MAIN_SIZE:0] ae_thr;
  logic               active;
  logic               pop_ok;
  logic               push_ok;
  logic               thr_ok;

  assign active = (state == ST_ACTIVE);
  assign empty  = (count == '0);
  assign full   = (count == DEPTH_C);

  // A push at full is only legal when a pop frees a slot in the same cycle.
  assign pop_ok  = active & pop & ~empty;
  assign push_ok = active & push & (~full | pop_ok);
  assign write   = push_ok;
  assign read    = pop_ok;

  assign almost_full  = (count >= af_thr);
  assign almost_empty = (count <= ae_thr);

  assign thr_ok = (afull_thr > aempty_thr) && (afull_thr <= DEPTH_C);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_INIT;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      valid_out     <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      af_thr        <= AF_C;
      ae_thr        <= AE_C;
    end else if (state == ST_INIT) begin
      state         <= ST_ACTIVE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      valid_out     <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      af_thr        <= thr_ok ? afull_thr  : AF_C;
      ae_thr        <= thr_ok ? aempty_thr : AE_C;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
      // memory_4x8 registers data_out, so the popped byte appears one cycle later
      valid_out <= pop_ok;
      if (push && full && !pop_ok) overflow_err  <= 1'b1;
      if (pop && empty)            underflow_err <= 1'b1;
      if (init) state <= ST_INIT;
    end
  end

endmodule
